// File: rtl/single_cycle_cpu.sv
// Single-cycle MIPS-I subset CPU with a unified word memory.
// Optional build macro: SYSCALL_HALT_EN -- when defined, SYSCALL freezes the PC
// and suppresses all writes until reset; otherwise SYSCALL is a NOP.

module single_cycle_cpu_memory #(
    parameter int MEM_WORDS = 4096
) (
    input  logic                         clk,
    input  logic [$clog2(MEM_WORDS)-1:0] i_iidx,
    input  logic [$clog2(MEM_WORDS)-1:0] i_didx,
    input  logic [31:0]                  i_wdata,
    input  logic                         i_we,
    output logic [31:0]                  o_idata,
    output logic [31:0]                  o_rdata
);
    logic [31:0] mem [0:MEM_WORDS-1];

    assign o_idata = mem[i_iidx];
    assign o_rdata = mem[i_didx];

    // Single write port; a load in the next cycle sees the new word.
    always_ff @(posedge clk) begin
        if (i_we) mem[i_didx] <= i_wdata;
    end
endmodule

module single_cycle_cpu #(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic clk,
    input  logic reset
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_SYS   = 6'h0C;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    logic [31:0] r_pc;
    logic [31:0] r_regs [0:31];

    logic [31:0] w_instr, w_rdata, w_rs_val, w_rt_val;
    logic [31:0] w_sext, w_zext, w_pc4, w_addr;
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_next_pc, w_reg_wdata;
    logic [4:0]  w_reg_waddr;
    logic        w_reg_we, w_mem_we;
    logic        w_unused_bits;

    assign w_op     = w_instr[31:26];
    assign w_rs     = w_instr[25:21];
    assign w_rt     = w_instr[20:16];
    assign w_rd     = w_instr[15:11];
    assign w_funct  = w_instr[5:0];
    assign w_sext   = {{16{w_instr[15]}}, w_instr[15:0]};
    assign w_zext   = {16'h0000, w_instr[15:0]};
    assign w_rs_val = (w_rs == 5'd0) ? 32'h0 : r_regs[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? 32'h0 : r_regs[w_rt];
    assign w_pc4    = r_pc + 32'd4;
    assign w_addr   = w_rs_val + w_sext;

    // Address bits outside the word index wrap silently.
    assign w_unused_bits = ^{w_addr[31:AW+2], w_addr[1:0], w_instr[10:6]};

    single_cycle_cpu_memory #(.MEM_WORDS(MEM_WORDS)) stage_MEMORY (
        .clk     (clk),
        .i_iidx  (r_pc[AW+1:2]),
        .i_didx  (w_addr[AW+1:2]),
        .i_wdata (w_rt_val),
        .i_we    (w_mem_we & ~reset),
        .o_idata (w_instr),
        .o_rdata (w_rdata)
    );

    // Decode and execute the current instruction; unknown encodings fall through as NOPs.
    always_comb begin
        w_next_pc   = w_pc4;
        w_reg_we    = 1'b0;
        w_reg_waddr = w_rt;
        w_reg_wdata = 32'h0;
        w_mem_we    = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_reg_waddr = w_rd;
                case (w_funct)
                    FN_ADD: begin w_reg_we = 1'b1; w_reg_wdata = w_rs_val + w_rt_val; end
                    FN_SUB: begin w_reg_we = 1'b1; w_reg_wdata = w_rs_val - w_rt_val; end
                    FN_SLT: begin
                        w_reg_we    = 1'b1;
                        w_reg_wdata = {31'h0, $signed(w_rs_val) < $signed(w_rt_val)};
                    end
                    FN_JR:  w_next_pc = w_rs_val;
`ifdef SYSCALL_HALT_EN
                    // Re-fetching the SYSCALL every cycle holds the core until reset.
                    FN_SYS: w_next_pc = r_pc;
`endif
                    default: ;
                endcase
            end
            OP_J:    w_next_pc = {w_pc4[31:28], w_instr[25:0], 2'b00};
            OP_JAL: begin
                w_next_pc   = {w_pc4[31:28], w_instr[25:0], 2'b00};
                w_reg_we    = 1'b1;
                w_reg_waddr = 5'd31;
                w_reg_wdata = w_pc4;
            end
            OP_BEQ:  if (w_rs_val == w_rt_val) w_next_pc = w_pc4 + {w_sext[29:0], 2'b00};
            OP_BNE:  if (w_rs_val != w_rt_val) w_next_pc = w_pc4 + {w_sext[29:0], 2'b00};
            OP_ADDI: begin w_reg_we = 1'b1; w_reg_wdata = w_rs_val + w_sext; end
            OP_XORI: begin w_reg_we = 1'b1; w_reg_wdata = w_rs_val ^ w_zext; end
            OP_LW:   begin w_reg_we = 1'b1; w_reg_wdata = w_rdata; end
            OP_SW:   w_mem_we = 1'b1;
            default: ;
        endcase
    end

    // Program counter update.
    always_ff @(posedge clk) begin
        if (reset) r_pc <= RESET_PC;
        else       r_pc <= w_next_pc;
    end

    // Register file write; $0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
        end else if (w_reg_we && (w_reg_waddr != 5'd0)) begin
            r_regs[w_reg_waddr] <= w_reg_wdata;
        end
    end
endmodule

// File: tb/tb_single_cycle_cpu.sv
// Directed bench for single_cycle_cpu with a scoreboard of expected state.
module tb_single_cycle_cpu;
    logic clk = 1'b0;
    logic reset = 1'b1;

    single_cycle_cpu dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;   // 0 = pc, 1 = register, 2 = memory word
        int          idx;
        logic [31:0] exp;
    } sb_t;

    sb_t q[$];
    int  n_pass = 0;
    int  n_total = 0;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    function automatic logic [31:0] observe(input int kind, input int idx);
        if (kind == 0)      return dut.r_pc;
        else if (kind == 1) return dut.r_regs[idx];
        else                return dut.stage_MEMORY.mem[idx];
    endfunction

    task automatic push(input string tag, input int kind, input int idx, input logic [31:0] exp);
        sb_t e;
        e.tag = tag; e.kind = kind; e.idx = idx; e.exp = exp;
        q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        logic [31:0] obs;
        while (q.size() > 0) begin
            e = q.pop_front();
            obs = observe(e.kind, e.idx);
            n_total++;
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) dut.stage_MEMORY.mem[i] = 32'h0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    logic [5:0]  br_op  [5] = '{6'h04, 6'h04, 6'h05, 6'h05, 6'h04};
    logic [15:0] br_b   [5] = '{16'd3, 16'd4, 16'd3, 16'd4, 16'd3};
    logic [15:0] br_off [5] = '{16'd2, 16'd2, 16'd2, 16'd2, 16'hFFFF};
    logic [31:0] br_pc  [5] = '{32'h1C, 32'h14, 32'h14, 32'h1C, 32'h10};

    initial begin
        // ADDI chain
        clear_mem();
        dut.stage_MEMORY.mem[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd5);
        dut.stage_MEMORY.mem[1] = enc_i(6'h08, 5'd8, 5'd9, 16'hFFF9);
        pulse_reset();
        push("reset_pc", 0, 0, 32'h0);
        drain();
        step(2);
        push("addi_t0", 1, 8, 32'd5);
        push("addi_t1", 1, 9, 32'hFFFF_FFFE);
        push("addi_pc", 0, 0, 32'h8);
        drain();

        // Store then load of the same word on consecutive cycles
        clear_mem();
        dut.stage_MEMORY.mem[0] = enc_i(6'h08, 5'd0, 5'd8, 16'h1234);
        dut.stage_MEMORY.mem[1] = enc_i(6'h2B, 5'd0, 5'd8, 16'h2000);
        dut.stage_MEMORY.mem[2] = enc_i(6'h23, 5'd0, 5'd10, 16'h2000);
        pulse_reset();
        step(3);
        push("sw_mem", 2, 2048, 32'h1234);
        push("lw_t2", 1, 10, 32'h1234);
        push("lwsw_pc", 0, 0, 32'hC);
        drain();

        // Branch table: BEQ/BNE at PC=0x10, taken and not taken, backward offset
        for (int k = 0; k < 5; k++) begin
            clear_mem();
            dut.stage_MEMORY.mem[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd3);
            dut.stage_MEMORY.mem[1] = enc_i(6'h08, 5'd0, 5'd9, br_b[k]);
            dut.stage_MEMORY.mem[4] = enc_i(br_op[k], 5'd8, 5'd9, br_off[k]);
            pulse_reset();
            step(5);
            push($sformatf("branch_pc_%0d", k), 0, 0, br_pc[k]);
            drain();
        end

        // JAL then JR back
        clear_mem();
        dut.stage_MEMORY.mem[2]  = enc_j(6'h03, 26'h40);
        dut.stage_MEMORY.mem[64] = enc_r(5'd31, 5'd0, 5'd0, 6'h08);
        pulse_reset();
        step(3);
        push("jal_pc", 0, 0, 32'h100);
        push("jal_ra", 1, 31, 32'hC);
        drain();
        step(1);
        push("jr_pc", 0, 0, 32'hC);
        drain();

        // ALU ops, $0 write, unknown opcode
        clear_mem();
        dut.stage_MEMORY.mem[0] = enc_i(6'h08, 5'd0, 5'd4, 16'hFFFF);
        dut.stage_MEMORY.mem[1] = enc_i(6'h08, 5'd0, 5'd5, 16'd1);
        dut.stage_MEMORY.mem[2] = enc_r(5'd4, 5'd5, 5'd6, 6'h2A);
        dut.stage_MEMORY.mem[3] = enc_r(5'd5, 5'd4, 5'd7, 6'h2A);
        dut.stage_MEMORY.mem[4] = enc_i(6'h0E, 5'd0, 5'd11, 16'hFFFF);
        dut.stage_MEMORY.mem[5] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
        dut.stage_MEMORY.mem[6] = enc_r(5'd4, 5'd5, 5'd12, 6'h20);
        dut.stage_MEMORY.mem[7] = enc_r(5'd0, 5'd5, 5'd13, 6'h22);
        dut.stage_MEMORY.mem[8] = enc_i(6'h3F, 5'd0, 5'd14, 16'd1);
        pulse_reset();
        step(9);
        push("slt_neg_lt", 1, 6, 32'd1);
        push("slt_pos_gt", 1, 7, 32'd0);
        push("xori_zext", 1, 11, 32'h0000_FFFF);
        push("zero_reg", 1, 0, 32'h0);
        push("add_wrap", 1, 12, 32'h0);
        push("sub_wrap", 1, 13, 32'hFFFF_FFFF);
        push("nop_no_write", 1, 14, 32'h0);
        push("alu_pc", 0, 0, 32'h24);
        drain();

        // Reset in the middle of a store
        clear_mem();
        dut.stage_MEMORY.mem[0]    = enc_i(6'h08, 5'd0, 5'd8, 16'h55);
        dut.stage_MEMORY.mem[1]    = enc_i(6'h2B, 5'd0, 5'd8, 16'h2004);
        dut.stage_MEMORY.mem[2049] = 32'hDEAD;
        pulse_reset();
        step(1);
        push("pre_reset_t0", 1, 8, 32'h55);
        drain();
        reset = 1'b1;
        step(1);
        push("mid_reset_pc", 0, 0, 32'h0);
        for (int r = 0; r < 32; r++) push($sformatf("mid_reset_r%0d", r), 1, r, 32'h0);
        push("mid_reset_mem", 2, 2049, 32'hDEAD);
        push("mid_reset_text", 2, 0, 32'h2008_0055);
        drain();
        reset = 1'b0;
        step(2);
        push("resume_sw", 2, 2049, 32'h55);
        push("resume_pc", 0, 0, 32'h8);
        drain();

        // SYSCALL behaviour
        clear_mem();
        dut.stage_MEMORY.mem[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd1);
        dut.stage_MEMORY.mem[1] = enc_r(5'd0, 5'd0, 5'd0, 6'h0C);
        dut.stage_MEMORY.mem[2] = enc_i(6'h08, 5'd0, 5'd9, 16'd7);
        pulse_reset();
        step(12);
        push("sys_t0", 1, 8, 32'd1);
`ifdef SYSCALL_HALT_EN
        push("sys_halt_pc", 0, 0, 32'h4);
        push("sys_halt_t1", 1, 9, 32'h0);
`else
        push("sys_nop_pc", 0, 0, 32'h30);
        push("sys_nop_t1", 1, 9, 32'd7);
`endif
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/single_cycle_cpu.md
SINGLE_CYCLE_CPU -- requirements
Module: single_cycle_cpu

Interface
REQ-001 Parameter: MEM_WORDS, 4096, depth of the unified 32-bit word memory.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, byte address loaded into PC on reset.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 No other ports; the sole observable state is internal.
REQ-006 Internal memory instance stage_MEMORY SHALL hold array mem [0:MEM_WORDS-1] of 32 bits, so external tools can preload and inspect it by that hierarchical path.

Function
REQ-007 Memory map: .text at word 0 (byte 0x0000); .data at word 2048 (byte 0x2000).
REQ-008 Memory is word addressed, index = byte_addr[13:2]; addr[1:0] and addr[31:14] are ignored (wrap-around, no fault).
REQ-009 Memory has two combinational read ports (instruction, data) and one write port written on the rising clk edge.
REQ-010 One instruction completes per cycle: PC, register and memory writes occur on the same edge.
REQ-011 Register file: 32x32; two combinational reads, one synchronous write; $0 reads 0 and ignores writes.
REQ-012 Supported MIPS-I subset: LW, SW, J, JAL, JR, BEQ, BNE, ADDI, XORI, ADD, SUB, SLT.
REQ-013 ADD/SUB/ADDI wrap modulo 2^32; no overflow trap.
REQ-014 SLT is a signed compare, writing 1 or 0 to rd.
REQ-015 ADDI, LW, SW and branch offsets are sign-extended; XORI immediates are zero-extended.
REQ-016 Default next PC is PC+4.
REQ-017 A taken branch sets PC to PC+4+(sext(imm)<<2).
REQ-018 J/JAL set PC to {PC+4[31:28], target, 2'b00}.
REQ-019 JAL also writes PC+4 to $31.
REQ-020 JR sets PC to rs.
REQ-021 Unrecognized opcode/funct executes as a NOP: PC+4, no register or memory write.
REQ-022 LW writes rt with mem[addr]; SW writes rt to mem[addr] on the edge. A load in the cycle after a store to the same address returns the new value.

Reset
REQ-023 While reset=1 at a rising edge: PC<=RESET_PC and all 32 registers <=0.
REQ-024 While reset=1 at a rising edge: no memory write occurs.
REQ-025 Memory contents are never altered by reset.
REQ-026 Reset asserted mid-program aborts the current instruction, discarding its writes.
REQ-027 Execution resumes from RESET_PC on the first edge after reset is released.

Configuration
REQ-028 Macro SYSCALL_HALT_EN, defined: SYSCALL (opcode 0, funct 0x0C) freezes PC and suppresses all writes until reset.
REQ-029 Macro SYSCALL_HALT_EN, undefined: SYSCALL is a NOP.

Verification
REQ-030 Reset pulse, then mem[0]=ADDI $t0,$0,5 and mem[1]=ADDI $t1,$t0,-7 -> $t0=5, $t1=0xFFFFFFFE, PC=8 after 2 cycles.
REQ-031 SW $t0,0x2000($0) with $t0=0x1234, then LW $t2,0x2000($0) -> mem[2048]=0x1234, $t2=0x1234.
REQ-032 BEQ with equal operands and offset 2 at PC=0x10 -> PC=0x1C; with unequal operands -> PC=0x14; BNE gives the inverse.
REQ-033 JAL target 0x40 at PC=0x8 -> PC=0x100, $31=0xC; then JR $31 -> PC=0xC.
REQ-034 SLT with $a=0xFFFFFFFF, $b=1 -> rd=1; XORI $t,$0,0xFFFF -> 0x0000FFFF; ADDI $0,$0,9 -> $0 stays 0.
REQ-035 Reset asserted mid-program -> PC=0 and all registers 0 on that edge, with memory unchanged; under SYSCALL_HALT_EN a SYSCALL holds PC constant for 10 or more cycles.
